// File: rtl/fetch_queue.sv
// fetch_queue: program-ordered instruction buffer between fetch and decode,
// tracking the end-of-program marker and supporting a pipeline flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_instr,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             last_accepted_reg;
    logic             drained_reg;
    logic             push;
    logic             pop;
    logic             head_last;
    logic [DEPTH-1:0] wr_sel;

    // in_ready depends only on registered state and flush, never on out_ready.
    assign in_ready  = (count_reg < CW'(DEPTH)) && !last_accepted_reg && !flush;
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    assign out_pc    = pc_mem[rd_ptr_reg];
    assign out_instr = instr_mem[rd_ptr_reg];
    assign head_last = last_mem[rd_ptr_reg];
    assign count     = count_reg;
    assign drained   = drained_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage is not reset; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                pc_mem[i]    <= in_pc;
                instr_mem[i] <= in_instr;
                last_mem[i]  <= in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            last_accepted_reg <= 1'b0;
            drained_reg       <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            last_accepted_reg <= 1'b0;
            drained_reg       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (in_last) begin
                    last_accepted_reg <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                if (head_last) begin
                    drained_reg <= 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a vector table, directed corner-case sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [2:0]      count;
    logic            drained;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .count(count), .drained(drained)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pop_total = 0;

    // Reference model: a plain FIFO of entries plus the two sticky flags.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        last;
    } ent_t;
    ent_t mq[$];
    bit   m_last_acc = 0;
    bit   m_drained  = 0;

    typedef struct packed {
        logic        fl, iv;
        logic [31:0] pc, instr;
        logic        il, orr;
        logic        e_in_ready, e_out_valid;
        logic [31:0] e_pc, e_instr;
        logic [2:0]  e_count;
        logic        e_drained;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_in_ready(input logic fl);
        return (mq.size() < DEPTH) && !m_last_acc && !fl;
    endfunction

    // Drive one cycle's inputs at the falling edge and check outputs against the model.
    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] instr, input logic il, input logic orr);
        @(negedge clk);
        flush = fl; in_valid = iv; in_pc = pc; in_instr = instr;
        in_last = il; out_ready = orr;
        #1;
        chk("model_in_ready", 32'(in_ready), 32'(m_in_ready(fl)));
        chk("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("model_count", 32'(count), 32'(mq.size()));
        chk("model_drained", 32'(drained), 32'(m_drained));
        if (mq.size() != 0) begin
            chk("model_out_pc", out_pc, mq[0].pc);
            chk("model_out_instr", out_instr, mq[0].instr);
        end
    endtask

    // Advance through the rising edge and apply the same cycle to the model.
    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = in_valid && m_in_ready(flush);
        do_pop  = (mq.size() != 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_last_acc = 0;
            m_drained  = 0;
            $display("[TB] flush");
        end else begin
            if (do_pop) begin
                $display("[TB] pop  pc=%h instr=%h last=%0b", mq[0].pc, mq[0].instr, mq[0].last);
                if (mq[0].last) m_drained = 1;
                void'(mq.pop_front());
                pop_total++;
            end
            if (do_push) begin
                e.pc = in_pc; e.instr = in_instr; e.last = in_last;
                mq.push_back(e);
                if (in_last) m_last_acc = 1;
            end
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        vecs[0] = '{1'b0, 1'b1, 32'h00, 32'h00500093, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h04, 32'h00A00113, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 32'h00500093, 3'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h08, 32'h002081B3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 32'h00A00113, 3'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 32'h002081B3, 3'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic order from the vector table; row 0 also covers reset values.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].il, vecs[i].orr);
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_in_ready));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_out_valid));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("tbl%0d_drained", i), 32'(drained), 32'(vecs[i].e_drained));
            if (vecs[i].e_out_valid) begin
                chk($sformatf("tbl%0d_out_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("tbl%0d_out_instr", i), out_instr, vecs[i].e_instr);
            end
            tick();
        end

        // Fill and backpressure: 4 accepts, the 5th waits until after the first pop.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h100 + 32'(i * 4), ins(32'h100 + 32'(i * 4)), 0, 0);
            tick();
        end
        drive(0, 1, 32'h110, ins(32'h110), 0, 0);
        chk("fill_count_full", 32'(count), 32'd4);
        chk("fill_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        drive(0, 1, 32'h110, ins(32'h110), 0, 1);
        chk("fill_pop_cycle_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head_pc", out_pc, 32'h100);
        tick();
        drive(0, 1, 32'h110, ins(32'h110), 0, 1);
        chk("fill_in_ready_after_pop", 32'(in_ready), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("fill_empty_after_drain", 32'(count), 32'd0);
        tick();

        // Wrap-around: 10 pushes, count held at 2 while streaming.
        pops0 = pop_total;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 32'(i * 4), ins(32'(i * 4)), 0, (i >= 2));
            if (i >= 2) chk("wrap_count", 32'(count), 32'd2);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            tick();
        end
        chk("wrap_pop_total", 32'(pop_total - pops0), 32'd10);

        // End of program: last flag on PC 0x08.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'(i * 4), ins(32'(i * 4)), (i == 2), 0);
            tick();
        end
        drive(0, 1, 32'h0C, ins(32'h0C), 0, 0);
        chk("eop_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h0C, ins(32'h0C), 0, 1);
            chk("eop_not_drained_yet", 32'(drained), 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h0C, ins(32'h0C), 0, 1);
            chk("eop_drained_sticky", 32'(drained), 32'd1);
            chk("eop_queue_empty", 32'(out_valid), 32'd0);
            tick();
        end

        // Flush with 3 entries queued and concurrent push/pop requests.
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_clears_drained", 32'(drained), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h200 + 32'(i * 4), ins(32'h200 + 32'(i * 4)), 0, 0);
            tick();
        end
        drive(1, 1, 32'h20C, ins(32'h20C), 0, 1);
        chk("flush_in_ready_forced_low", 32'(in_ready), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_drained", 32'(drained), 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));
            tick();
        end

        // Asynchronous reset while full.
        drive(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h300 + 32'(i * 4), ins(32'h300 + 32'(i * 4)), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("areset_pre_full", 32'(count), 32'd4);
        #1 reset = 1'b1;
        #1;
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_in_ready", 32'(in_ready), 32'd1);
        chk("areset_drained", 32'(drained), 32'd0);
        mq.delete();
        m_last_acc = 0;
        m_drained  = 0;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 32'h400, ins(32'h400), 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("areset_recover_pc", out_pc, 32'h400);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between the instruction fetch stage and the decode stage. It captures each fetched instruction word with its PC and presents them in program order to decode under a valid/ready handshake. It also tracks the end-of-program marker, so the top level sees a single "program drained" indication instead of the raw fetch-complete pulse. It supports a pipeline flush that discards all buffered instructions.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, width of PC and instruction words

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- flush  input  1  synchronous discard of all entries and end-of-program state
- in_valid  input  1  fetch presents an instruction this cycle
- in_ready  output  1  queue accepts an instruction this cycle
- in_pc  input  XLEN  PC of the presented instruction
- in_instr  input  XLEN  instruction word
- in_last  input  1  presented instruction is the final one of the program
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head entry this cycle
- out_pc  output  XLEN  PC of head entry
- out_instr  output  XLEN  instruction word of head entry
- count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH
- drained  output  1  last instruction has been consumed by decode; sticky

## Operation
- Storage: DEPTH entries of {pc, instr, last}. Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. An occupancy counter drives `count`.
- Push occurs when in_valid && in_ready. The entry is written at the write pointer, and the write pointer increments.
- Pop occurs when out_valid && out_ready. The read pointer increments.
- in_ready = (count < DEPTH) && !last_accepted && !flush. It is purely registered-state driven, with no combinational path from out_ready.
- out_valid = (count != 0). out_pc, out_instr and the head last flag are read from the entry at the read pointer.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, a pop does not enable a push in the same cycle, because in_ready is already low.
- last_accepted (internal): set on a push with in_last=1. After it is set, in_ready stays 0 until flush or reset, so no instructions are accepted past the end of the program.
- drained: set on the cycle after a pop whose head entry has last=1. It holds 1 until flush or reset.
- flush has highest priority. On the next edge:
  - both pointers and count go to 0;
  - last_accepted and drained go to 0;
  - any push or pop in that cycle is ignored.
  - in_ready is forced 0 during the flush cycle.
- Reset (asynchronous, active-high) has the same clearing effect as flush, applied immediately. Storage contents are don't-care.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, count=0, drained=0;
  - out_pc and out_instr are don't-care while out_valid=0.
- Latency: an instruction pushed at edge N is visible on out_* after edge N, so it can be popped at edge N+1. There is no bypass: an empty queue gives out_valid=0 in the push cycle.
- Throughput: one push and one pop per cycle in steady state with 0 < count < DEPTH.
- Full (count=DEPTH): in_ready=0. A pop this cycle raises in_ready on the following cycle.
- Empty (count=0): out_valid=0, and out_ready is ignored.
- drained rises exactly one cycle after the pop edge of the last-flagged entry.
- Reset asserted mid-stream: all outputs return to reset values asynchronously, without waiting for a clock edge.

## Test plan
- Basic order:
  - Stimulus: push PCs 0x00, 0x04, 0x08 with instrs 0x00500093, 0x00A00113, 0x002081B3, out_ready=1.
  - Required response: outputs appear in that order, the first one cycle after its push; count peaks at 1.
- Fill/backpressure:
  - Stimulus: out_ready=0 and push 5 instructions with DEPTH=4.
  - Required response: after 4 accepts count=4 and in_ready=0, and the 5th is held by fetch.
  - Then release out_ready: entries drain in order, and the 5th is accepted the cycle after the first pop.
- Wrap-around:
  - Stimulus: 10 pushes interleaved with pops, keeping count at 2.
  - Required response: PCs 0x00..0x24 emerge in order with no loss or duplication.
- End of program:
  - Stimulus: push 3 instructions with in_last=1 on PC 0x08.
  - Required response: in_ready=0 from the cycle after that accept; drained=1 the cycle after 0x08 pops and stays 1.
- Flush:
  - Stimulus: with 3 entries queued, assert flush together with in_valid and out_ready.
  - Required response: next cycle count=0, out_valid=0 and drained=0; neither the concurrent push nor the pop takes effect.
- Async reset:
  - Stimulus: assert reset between clock edges while full.
  - Required response: count=0, out_valid=0 and in_ready=1 before the next edge.
